boid_fetch_arbiter: RTL and testbench

BOID_FETCH_ARBITER -- requirements
Module: boid_fetch_arbiter

---
 rtl/boids_mem_defs_pkg.sv | 25 ++
 rtl/starve_timer.sv | 33 +++
 rtl/boid_fetch_arbiter.sv | 142 ++++++++++++++
 tb/tb_boid_fetch_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boids_mem_defs_pkg.sv
// Shared definitions for the boid memory subsystem: bus widths, default table base, fetch FSM encoding.
// No logic of its own; zero latency.
// No flow control; consumers import the types and helpers.
package boids_mem_defs_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;

  // RAM word address of boid entry 0 in the default memory map.
  localparam logic [ADDR_W-1:0] BOID_BASE_DEFAULT = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Word address of a boid entry; the sum wraps around the 4K-word RAM.
  function automatic logic [ADDR_W-1:0] boid_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + {{(ADDR_W-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/starve_timer.sv
// Counts consecutive denied fetch cycles and flags when the fetcher must be forced through.
// expired is a direct decode of the registered count (no added latency).
// No flow control; clear has priority over deny and the count saturates at LIMIT.
module starve_timer #(
  parameter int LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic deny,
  output logic expired
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT_CNT = LIMIT[CNT_W-1:0];

  logic [CNT_W-1:0] cnt;

  // Denied-cycle counter: cleared on grant/entry, saturating so it never passes LIMIT.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (deny && (cnt != LIMIT_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT_CNT);

  // The count must never run past the limit.
  cnt_bounded: assert property (@(posedge clock) disable iff (reset) cnt <= LIMIT_CNT);

endmodule

// File: rtl/boid_fetch_arbiter.sv
// Shares one single-port RAM between the CPU and a per-frame boid table fetcher.
// Grant/mux is combinational; fetched words appear one cycle after their read is granted.
// CPU is stalled (must hold its request) only on cycles the fetcher wins; starvation forces a fetch win.
module boid_fetch_arbiter
  import boids_mem_defs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BOID_BASE    = BOID_BASE_DEFAULT,
  parameter int                BOID_COUNT   = 64,
  parameter int                STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              frame_start,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              fb_valid,
  output logic [IDX_W-1:0]  fb_index,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_busy,
  output logic              fb_done,
  output logic              fb_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOID_COUNT - 1);

  fetch_state_e     state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             in_flight, in_flight_nxt;
  logic [IDX_W-1:0] fb_idx_q, fb_idx_nxt;
  logic             done_q, done_nxt;
  logic             overrun_q, overrun_nxt;

  logic             fetch_grant;
  logic             starve_expired;
  logic             starve_clear;
  logic             starve_deny;

  starve_timer #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .clear   (starve_clear),
    .deny    (starve_deny),
    .expired (starve_expired)
  );

  // Grant decision, RAM port mux and next-state for the fetch sequencer.
  always_comb begin
    fetch_grant   = 1'b0;
    starve_clear  = 1'b0;
    starve_deny   = 1'b0;
    ram_wen       = 1'b0;
    ram_addr      = cpu_addr;
    ram_wdata     = cpu_wdata;
    cpu_stall     = 1'b0;
    state_nxt     = state;
    idx_nxt       = idx;
    in_flight_nxt = 1'b0;
    fb_idx_nxt    = fb_idx_q;
    done_nxt      = 1'b0;
    overrun_nxt   = overrun_q;

    if (state == ST_FETCH) begin
      fetch_grant = !cpu_req || starve_expired;
      starve_deny = !fetch_grant;
    end

    if (fetch_grant) begin
      // Fetcher owns the RAM: read only, CPU told to hold whatever it asked for.
      ram_addr      = boid_addr(BOID_BASE, idx);
      cpu_stall     = cpu_req;
      idx_nxt       = idx + 1'b1;
      in_flight_nxt = 1'b1;
      fb_idx_nxt    = idx;
      done_nxt      = (idx == LAST_IDX);
      starve_clear  = 1'b1;
      if (idx == LAST_IDX) begin
        state_nxt = ST_DRAIN;
      end
    end else begin
      ram_wen = cpu_wen;
    end

    if (state == ST_DRAIN) begin
      state_nxt = ST_IDLE;
    end

    // A new frame always wins: restart from entry 0 and drop any read in flight.
    if (frame_start) begin
      if (state != ST_IDLE) begin
        overrun_nxt = 1'b1;
      end
      state_nxt     = ST_FETCH;
      idx_nxt       = '0;
      in_flight_nxt = 1'b0;
      done_nxt      = 1'b0;
      starve_clear  = 1'b1;
    end

    // No RAM write may slip through while the system is held in reset.
    if (reset) begin
      ram_wen = 1'b0;
    end
  end

  // All sequencer state, reset synchronously.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      in_flight <= 1'b0;
      fb_idx_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      in_flight <= in_flight_nxt;
      fb_idx_q  <= fb_idx_nxt;
      done_q    <= done_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign cpu_rdata  = ram_rdata;
  assign fb_valid   = in_flight;
  assign fb_index   = fb_idx_q;
  assign fb_data    = ram_rdata;
  assign fb_done    = done_q;
  assign fb_busy    = (state != ST_IDLE);
  assign fb_overrun = overrun_q;

endmodule

// File: tb/tb_boid_fetch_arbiter.sv
// Bench for boid_fetch_arbiter: two instances (table at 0x800 and at 0xFFE) share one stimulus stream.
// Each has its own 4K-word RAM with one-cycle read latency.
// A cycle-level reference model built from the arbitration rules is checked every cycle.
module tb_boid_fetch_arbiter;

  localparam int          COUNT = 4;
  localparam int          LIMIT = 8;
  localparam logic [11:0] BASE0 = 12'h800;
  localparam logic [11:0] BASE1 = 12'hFFE;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, cpu_req, cpu_wen, frame_start, tb_init;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;

  logic [1:0][31:0] cpu_rdata, ram_wdata, fb_data;
  logic [1:0][11:0] ram_addr;
  logic [1:0][7:0]  fb_index;
  logic [1:0]       cpu_stall, ram_wen, fb_valid, fb_busy, fb_done, fb_overrun;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'hB0000000 | ({20'h0, a} * 32'h00010001);
  endfunction

  function automatic logic [11:0] base_of(input int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] rdata;
    logic [31:0] mem [4096];

    boid_fetch_arbiter #(
      .BOID_BASE    (g == 0 ? BASE0 : BASE1),
      .BOID_COUNT   (COUNT),
      .STARVE_LIMIT (LIMIT)
    ) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_wen     (cpu_wen),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata[g]),
      .cpu_stall   (cpu_stall[g]),
      .frame_start (frame_start),
      .ram_wen     (ram_wen[g]),
      .ram_addr    (ram_addr[g]),
      .ram_wdata   (ram_wdata[g]),
      .ram_rdata   (rdata),
      .fb_valid    (fb_valid[g]),
      .fb_index    (fb_index[g]),
      .fb_data     (fb_data[g]),
      .fb_busy     (fb_busy[g]),
      .fb_done     (fb_done[g]),
      .fb_overrun  (fb_overrun[g])
    );

    // Single-port RAM, read data one cycle after the address.
    always @(posedge clock) begin
      if (tb_init) begin
        for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
      end else if (ram_wen[g]) begin
        mem[ram_addr[g]] <= ram_wdata[g];
      end
      rdata <= mem[ram_addr[g]];
    end
  end

  // Reference model state: what the arbiter must be doing, in plain terms.
  logic [31:0] exp_mem [4096];
  logic        m_fetch, m_drain, m_pend, m_plast, m_over, m_rd_pend, m_hold;
  int          m_idx, m_wait, m_pidx;
  logic [31:0] m_pdata [2];
  logic [31:0] m_rd_data;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic step(input logic fs, input logic rst, input logic req, input logic wen,
                      input logic [11:0] a, input logic [31:0] d);
    logic        grant, exp_wen, rd_n;
    logic [11:0] fa [2];
    @(negedge clock);
    frame_start = fs;
    reset       = rst;
    if (!m_hold) begin
      cpu_req   = req;
      cpu_wen   = req & wen;
      cpu_addr  = a;
      cpu_wdata = d;
    end
    #1;
    grant   = m_fetch && (!cpu_req || (m_wait == LIMIT));
    exp_wen = !rst && !grant && cpu_wen;
    for (int k = 0; k < 2; k++) begin
      fa[k] = base_of(k) + 12'(m_idx);
      chk("ram_wen", k, ram_wen[k], exp_wen);
      chk("ram_addr", k, ram_addr[k], grant ? fa[k] : cpu_addr);
      if (exp_wen) chk("ram_wdata", k, ram_wdata[k], cpu_wdata);
      chk("cpu_stall", k, cpu_stall[k], grant && cpu_req);
      chk("fb_valid", k, fb_valid[k], m_pend);
      if (m_pend) begin
        chk("fb_index", k, fb_index[k], m_pidx);
        chk("fb_data", k, fb_data[k], m_pdata[k]);
      end
      chk("fb_done", k, fb_done[k], m_pend && m_plast);
      chk("fb_busy", k, fb_busy[k], m_fetch || m_drain);
      chk("fb_overrun", k, fb_overrun[k], m_over);
      if (m_rd_pend) chk("cpu_rdata", k, cpu_rdata[k], m_rd_data);
    end
    m_hold = grant && cpu_req;
    if (rst) begin
      m_fetch = 0; m_drain = 0; m_idx = 0; m_wait = 0;
      m_pend = 0; m_over = 0; m_rd_pend = 0;
    end else begin
      rd_n = 0;
      if (!grant && cpu_req) begin
        if (cpu_wen) exp_mem[cpu_addr] = cpu_wdata;
        else begin
          rd_n = 1;
          m_rd_data = exp_mem[cpu_addr];
        end
      end
      m_rd_pend = rd_n;
      if (fs) begin
        if (m_fetch || m_drain) m_over = 1;
        m_fetch = 1; m_drain = 0; m_idx = 0; m_wait = 0; m_pend = 0;
      end else if (m_fetch) begin
        if (grant) begin
          m_pend  = 1;
          m_pidx  = m_idx;
          m_plast = (m_idx == COUNT - 1);
          for (int k = 0; k < 2; k++) m_pdata[k] = exp_mem[fa[k]];
          m_idx++;
          m_wait = 0;
          if (m_plast) begin
            m_fetch = 0;
            m_drain = 1;
          end
        end else begin
          m_wait++;
          m_pend = 0;
        end
      end else begin
        m_drain = 0;
        m_pend  = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 12'h0, 32'h0);
  endtask

  initial begin
    logic [11:0] a1_seq [4];
    int nw, nd;
    a1_seq = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    for (int i = 0; i < 4096; i++) exp_mem[i] = pat(12'(i));
    m_fetch = 0; m_drain = 0; m_pend = 0; m_plast = 0; m_over = 0;
    m_rd_pend = 0; m_hold = 0; m_idx = 0; m_wait = 0; m_pidx = 0; m_rd_data = 0;
    m_pdata[0] = 0; m_pdata[1] = 0;
    reset = 1; tb_init = 1; frame_start = 0;
    cpu_req = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;

    // Reset state.
    step(0, 1, 0, 0, 12'h0, 32'h0);
    tb_init = 0;
    step(0, 1, 1, 1, 12'h123, 32'h1);
    chk("rst_ram_wen", 0, ram_wen[0], 0);
    chk("rst_fb_valid", 0, fb_valid[0], 0);
    chk("rst_fb_busy", 0, fb_busy[0], 0);
    chk("rst_fb_done", 0, fb_done[0], 0);
    chk("rst_fb_overrun", 0, fb_overrun[0], 0);
    idle(3);

    // Uncontended frame: four back-to-back words, wrap of the 0xFFE table.
    step(1, 0, 0, 0, 12'h0, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      step(0, 0, 0, 0, 12'h0, 32'h0);
      if (c <= 4) begin
        chk("wrap_addr", 1, ram_addr[1], a1_seq[c-1]);
        chk("seq_addr", 0, ram_addr[0], 12'h800 + 12'(c - 1));
      end
      if (c >= 2 && c <= 5) begin
        chk("seq_valid", 0, fb_valid[0], 1);
        chk("seq_index", 0, fb_index[0], c - 2);
        chk("seq_data", 0, fb_data[0], 32'hB8000800 + (c - 2) * 32'h00010001);
      end
      chk("seq_done", 0, fb_done[0], c == 5);
      chk("seq_busy", 0, fb_busy[0], c <= 5);
    end
    idle(2);

    // CPU requesting every cycle: fetcher wins once per 9 cycles; stalled write lands once.
    nw = 0;
    step(1, 0, 1, 0, 12'h010, 32'h0);
    for (int c = 1; c <= 40; c++) begin
      step(0, 0, 1, c == 9, (c == 9) ? 12'h123 : 12'h010, 32'hCAFE0009);
      chk("starve_stall", 0, cpu_stall[0], (c % 9 == 0) && (c <= 36));
      if (c == 37) chk("starve_done", 0, fb_done[0], 1);
      if (ram_wen[0] && ram_addr[0] == 12'h123) nw++;
    end
    chk("write_once", 0, nw, 1);
    idle(2);

    // CPU write to the next entry defers the fetch and is seen by it.
    step(1, 0, 0, 0, 12'h0, 32'h0);
    step(0, 0, 0, 0, 12'h0, 32'h0);
    step(0, 0, 1, 1, 12'h801, 32'hDEADBEEF);
    chk("defer_stall", 0, cpu_stall[0], 0);
    chk("defer_wen", 0, ram_wen[0], 1);
    chk("defer_addr", 0, ram_addr[0], 12'h801);
    step(0, 0, 0, 0, 12'h0, 32'h0);
    chk("defer_fetch_addr", 0, ram_addr[0], 12'h801);
    step(0, 0, 0, 0, 12'h0, 32'h0);
    chk("defer_index", 0, fb_index[0], 1);
    chk("defer_data", 0, fb_data[0], 32'hDEADBEEF);
    idle(5);

    // Restart mid-frame: in-flight word dropped, overrun sticky, one done after four words.
    nd = 0;
    step(1, 0, 0, 0, 12'h0, 32'h0);
    step(0, 0, 0, 0, 12'h0, 32'h0);
    step(0, 0, 0, 0, 12'h0, 32'h0);
    step(1, 0, 0, 0, 12'h0, 32'h0);
    for (int c = 4; c <= 12; c++) begin
      step(0, 0, 0, 0, 12'h0, 32'h0);
      if (c == 4) begin
        chk("restart_valid", 0, fb_valid[0], 0);
        chk("restart_overrun", 0, fb_overrun[0], 1);
      end
      if (c == 5) begin
        chk("restart_valid1", 0, fb_valid[0], 1);
        chk("restart_index", 0, fb_index[0], 0);
      end
      if (c == 8) chk("restart_done", 0, fb_done[0], 1);
      if (fb_done[0]) nd++;
    end
    chk("restart_done_count", 0, nd, 1);

    // Reset in the middle of a fetch.
    step(1, 0, 0, 0, 12'h0, 32'h0);
    step(0, 0, 0, 0, 12'h0, 32'h0);
    step(0, 1, 1, 1, 12'h055, 32'h11111111);
    chk("midrst_ram_wen", 0, ram_wen[0], 0);
    step(0, 0, 0, 0, 12'h0, 32'h0);
    chk("midrst_valid", 0, fb_valid[0], 0);
    chk("midrst_busy", 0, fb_busy[0], 0);
    chk("midrst_done", 0, fb_done[0], 0);
    chk("midrst_overrun", 0, fb_overrun[0], 0);
    chk("midrst_stall", 0, cpu_stall[0], 0);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 12'h0, 32'h0);
      chk("midrst_quiet", 0, fb_valid[0], 0);
    end
    step(0, 0, 1, 0, 12'h055, 32'h0);
    idle(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        fs, rst, req, wen;
      logic [11:0] a;
      int          dens;
      dens = (i / 500) % 3;
      fs   = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 599) == 0);
      req  = (dens == 0) ? ($urandom_range(0, 3) == 0) :
             (dens == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) != 0);
      wen  = $urandom_range(0, 1);
      a    = $urandom_range(0, 1) ? (12'h7F8 + 12'($urandom_range(0, 15)))
                                  : (12'hFF8 + 12'($urandom_range(0, 15)));
      step(fs, rst, req, wen, a, $urandom);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
